// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/opcode widths, opcode constants, interface FSM encoding.
package alu_pkg;

  localparam int SIZEDATA = 8;
  localparam int SIZEOP   = 6;

  localparam logic [SIZEOP-1:0] OP_ADD = 6'h20;
  localparam logic [SIZEOP-1:0] OP_SUB = 6'h22;
  localparam logic [SIZEOP-1:0] OP_OR  = 6'h25;
  localparam logic [SIZEOP-1:0] OP_AND = 6'h24;
  localparam logic [SIZEOP-1:0] OP_NOR = 6'h27;
  localparam logic [SIZEOP-1:0] OP_XOR = 6'h26;
  localparam logic [SIZEOP-1:0] OP_SRL = 6'h02;
  localparam logic [SIZEOP-1:0] OP_SRA = 6'h03;

  typedef enum logic [2:0] {
    WAIT_A    = 3'd0,
    WAIT_B    = 3'd1,
    WAIT_OP   = 3'd2,
    COMPUTE   = 3'd3,
    SEND      = 3'd4,
    WAIT_ACK  = 3'd5,
    WAIT_DONE = 3'd6
  } state_t;

  function automatic logic is_valid_op(input logic [SIZEOP-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_NOR, OP_XOR, OP_SRL, OP_SRA: is_valid_op = 1'b1;
      default: is_valid_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_interface_frame_timer.sv
// Inter-byte timeout counter: clears on CLEAR, counts while EN, flags when TIMEOUT cycles elapsed.
module frame_timer #(
  parameter int TIMEOUT = 100000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLEAR,
  input  logic EN,
  output logic EXPIRED
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturates at LAST so EXPIRED stays asserted until the FSM reacts.
  always_comb begin
    count_d = count_q;
    if (CLEAR) begin
      count_d = '0;
    end else if (EN && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign EXPIRED = EN && (count_q == LAST);

endmodule

// File: rtl/alu_interface.sv
// UART-to-ALU bridge: collects operand A, operand B and opcode bytes, then transmits the result byte.
module alu_interface #(
  parameter int SIZEDATA = alu_pkg::SIZEDATA,
  parameter int SIZEOP   = alu_pkg::SIZEOP,
  parameter int TIMEOUT  = 100000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [7:0]          RX_DATA,
  input  logic                RX_DONE,
  input  logic                TX_BUSY,
  input  logic [SIZEDATA-1:0] RESULT,
  output logic [SIZEDATA-1:0] DATOA,
  output logic [SIZEDATA-1:0] DATOB,
  output logic [SIZEOP-1:0]   OPCODE,
  output logic [7:0]          TX_DATA,
  output logic                TX_START,
  output logic                ERR
);

  import alu_pkg::*;

  state_t              state_q, state_d;
  logic [SIZEDATA-1:0] datoa_q, datoa_d;
  logic [SIZEDATA-1:0] datob_q, datob_d;
  logic [SIZEOP-1:0]   opcode_q, opcode_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                err_q, err_d;
  logic                rx_accept_s;
  logic                timer_clear_s;
  logic                timer_en_s;
  logic                timer_expired_s;

  assign timer_en_s    = (state_q == WAIT_B) || (state_q == WAIT_OP) || (state_q == WAIT_ACK);
  assign timer_clear_s = (state_d != state_q) || rx_accept_s;

  frame_timer #(.TIMEOUT(TIMEOUT)) u_frame_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .CLEAR   (timer_clear_s),
    .EN      (timer_en_s),
    .EXPIRED (timer_expired_s)
  );

  // Bytes arriving while a result is in flight are dropped with ERR but never stall the frame.
  always_comb begin
    state_d     = state_q;
    datoa_d     = datoa_q;
    datob_d     = datob_q;
    opcode_d    = opcode_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    err_d       = 1'b0;
    rx_accept_s = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (RX_DONE) begin
          datoa_d     = SIZEDATA'(RX_DATA);
          rx_accept_s = 1'b1;
          state_d     = WAIT_B;
        end else begin
          state_d = WAIT_A;
        end
      end
      WAIT_B: begin
        if (RX_DONE) begin
          datob_d     = SIZEDATA'(RX_DATA);
          rx_accept_s = 1'b1;
          state_d     = WAIT_OP;
        end else if (timer_expired_s) begin
          err_d   = 1'b1;
          state_d = WAIT_A;
        end else begin
          state_d = WAIT_B;
        end
      end
      WAIT_OP: begin
        if (RX_DONE) begin
          rx_accept_s = 1'b1;
          if (is_valid_op(RX_DATA[5:0])) begin
            opcode_d = SIZEOP'(RX_DATA[5:0]);
            state_d  = COMPUTE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_A;
          end
        end else if (timer_expired_s) begin
          err_d   = 1'b1;
          state_d = WAIT_A;
        end else begin
          state_d = WAIT_OP;
        end
      end
      COMPUTE: begin
        err_d     = RX_DONE;
        tx_data_d = 8'(RESULT);
        state_d   = SEND;
      end
      SEND: begin
        err_d = RX_DONE;
        if (!TX_BUSY) begin
          tx_start_d = 1'b1;
          state_d    = WAIT_ACK;
        end else begin
          state_d = SEND;
        end
      end
      WAIT_ACK: begin
        err_d = RX_DONE;
        if (TX_BUSY) begin
          state_d = WAIT_DONE;
        end else if (timer_expired_s) begin
          err_d   = 1'b1;
          state_d = WAIT_A;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        err_d = RX_DONE;
        if (!TX_BUSY) begin
          state_d = WAIT_A;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= WAIT_A;
      datoa_q    <= '0;
      datob_q    <= '0;
      opcode_q   <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      datoa_q    <= datoa_d;
      datob_q    <= datob_d;
      opcode_q   <= opcode_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
    end
  end

  assign DATOA    = datoa_q;
  assign DATOB    = datob_q;
  assign OPCODE   = opcode_q;
  assign TX_DATA  = tx_data_q;
  assign TX_START = tx_start_q;
  assign ERR      = err_q;

endmodule
